mem_system: RTL and testbench
=============================

MEM_SYSTEM -- requirements
Module: mem_system

Interface
REQ-001 SHALL have parameter INIT_VAL, default 8'h00, value written to every location by the post-reset sweep.
REQ-002 SHALL have parameter FAULT_ADDR, default 8'h00, address of the injectable stuck-at fault.
REQ-003 SHALL have parameter FAULT_MASK, default 8'h01, bits of FAULT_ADDR forced when fault_en=1.
REQ-004 SHALL have parameter FAULT_VAL, default 8'h00, values of the forced bits.
REQ-005 SHALL have port clock  input  1  sole clock, all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port wra  input  8  write address.
REQ-009 SHALL have port wrd  input  8  write data.
REQ-010 SHALL have port rda  input  8  read address.
REQ-011 SHALL have port fault_en  input  1  enables the stuck-at fault on reads of FAULT_ADDR.
REQ-012 SHALL have port rdd  output  8  registered read data.
REQ-013 SHALL have port ready  output  1  high once the init sweep completes; drives the tester enable.
REQ-014 SHALL have port wcount  output  9  committed user writes, saturating at 9'h1FF.

Function
REQ-015 SHALL contain a 256x8 storage array; the array itself is not reset.
REQ-016 SHALL implement a two-state FSM: SWEEP (after reset) and RUN.
REQ-017 In SWEEP, SHALL write INIT_VAL to address sweep_ptr each cycle, sweep_ptr incrementing 0..255.
REQ-018 SHALL transition SWEEP->RUN on the edge that writes address 255; ready SHALL rise on that same edge (256 edges after reset release).
REQ-019 In SWEEP, SHALL ignore we/wra/wrd and hold rdd at 8'h00.
REQ-020 In RUN, SHALL capture we=1 with wra/wrd into a one-entry write stage (wb_valid, wb_addr, wb_data) on the rising edge.
REQ-021 SHALL commit a valid write stage to the array on the next rising edge; a new write captured on that edge SHALL replace the stage (back-to-back writes, one per cycle, no stall).
REQ-022 SHALL clear wb_valid on an edge with we=0 after committing.
REQ-023 SHALL increment wcount on each commit, holding at 9'h1FF.
REQ-024 In RUN, SHALL register rdd every rising edge from rda: latency one edge.
REQ-025 Read source: wb_data when wb_valid=1 and wb_addr==rda, else array[rda].
REQ-026 A write sampled on the same edge as a read of the same address SHALL NOT be forwarded; that read returns the prior value.
REQ-027 When fault_en=1 and rda==FAULT_ADDR, rdd SHALL be (src & ~FAULT_MASK) | (FAULT_VAL & FAULT_MASK); the stored data is unaffected.
REQ-028 Writes and reads to address 8'hFF SHALL behave as any other address; addresses SHALL NOT wrap or alias.

Reset
REQ-029 On reset=0, asynchronously: rdd=0, ready=0, wcount=0, wb_valid=0, sweep_ptr=0, state=SWEEP.
REQ-030 Reset asserted mid-sweep or mid-write SHALL discard any pending write stage, then restart the full sweep on release.
REQ-031 The first rising edge after release SHALL perform sweep write 0.

Verification
REQ-032 Release reset, INIT_VAL=8'hA5 -> ready=0 for 255 edges, ready=1 on edge 256; reads of 0, 128, 255 return 8'hA5 one edge later.
REQ-033 RUN: we=1, wra=8'h10, wrd=8'h3C on edge N; rda=8'h10 on edge N+1 -> rdd=8'h3C after edge N+1 (forwarded); wcount=1.
REQ-034 Writes to 8'h20 with 8'h11, 8'h22, 8'h33 on consecutive edges, then read 8'h20 -> rdd=8'h33; wcount=3.
REQ-035 fault_en=1, FAULT_ADDR=8'h40, MASK=8'h01, VAL=0; write 8'hFF to 8'h40, read -> rdd=8'hFE; fault_en=0, read -> rdd=8'hFF.
REQ-036 Pull reset low at sweep_ptr=100 -> outputs zero immediately; after release ready rises exactly 256 edges later.
REQ-037 Connect to the tester (ready->enable, negedge-driven we/wra/wrd/rda) -> done=1, t1attempts=t2attempts=256, t1fails=t2fails=0; with fault_en=1, FAULT_MASK=8'h01, FAULT_VAL=8'h01 -> t1fails=1, t2fails=0.

Source files
------------

// File: rtl/mem_system.sv
// 256x8 memory with post-reset init sweep, one-entry write stage,
// registered read port with forwarding and an injectable stuck-at fault.
module mem_system #(
  parameter logic [7:0] INIT_VAL   = 8'h00,
  parameter logic [7:0] FAULT_ADDR = 8'h00,
  parameter logic [7:0] FAULT_MASK = 8'h01,
  parameter logic [7:0] FAULT_VAL  = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] wra,
  input  logic [7:0] wrd,
  input  logic [7:0] rda,
  input  logic       fault_en,
  output logic [7:0] rdd,
  output logic       ready,
  output logic [8:0] wcount
);

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_mem [0:255];
  logic [7:0] r_ptr;
  logic       r_ready;
  logic       r_wb_valid;
  logic [7:0] r_wb_addr;
  logic [7:0] r_wb_data;
  logic [8:0] r_wcount;
  logic [7:0] r_rdd;

  logic       w_mem_we;
  logic [7:0] w_mem_addr;
  logic [7:0] w_mem_data;
  logic [7:0] w_src;
  logic [7:0] w_rd_val;
  logic       w_fault;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= SWEEP;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_mem_we   = 1'b0;
    w_mem_addr = r_ptr;
    w_mem_data = INIT_VAL;
    unique case (r_state)
      SWEEP: begin
        w_mem_we = 1'b1;
        if (r_ptr == 8'hFF) w_next = RUN;
      end
      RUN: begin
        w_mem_we   = r_wb_valid;
        w_mem_addr = r_wb_addr;
        w_mem_data = r_wb_data;
      end
    endcase
  end

  // Only a stage captured on an earlier edge is forwarded.
  assign w_src = (r_wb_valid && r_wb_addr == rda) ?
                 r_wb_data : r_mem[rda];
  assign w_fault = fault_en && (rda == FAULT_ADDR);
  assign w_rd_val = w_fault ?
    ((w_src & ~FAULT_MASK) | (FAULT_VAL & FAULT_MASK)) : w_src;

  always_ff @(posedge clock) begin
    if (w_mem_we && reset) r_mem[w_mem_addr] <= w_mem_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr      <= 8'h00;
      r_ready    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= 8'h00;
      r_wb_data  <= 8'h00;
      r_wcount   <= 9'h000;
      r_rdd      <= 8'h00;
    end else if (r_state == SWEEP) begin
      r_ptr      <= r_ptr + 8'h01;
      r_wb_valid <= 1'b0;
      r_rdd      <= 8'h00;
      if (r_ptr == 8'hFF) r_ready <= 1'b1;
    end else begin
      r_rdd      <= w_rd_val;
      r_wb_valid <= we;
      r_wb_addr  <= wra;
      r_wb_data  <= wrd;
      if (r_wb_valid && r_wcount != 9'h1FF)
        r_wcount <= r_wcount + 9'h001;
    end
  end

  assign rdd    = r_rdd;
  assign ready  = r_ready;
  assign wcount = r_wcount;

endmodule

// File: tb/tb_mem_system.sv
// Randomized bench for mem_system: a per-edge visibility model
// checked every cycle, plus hand-computed literal checks.
module tb_mem_system;

  localparam logic [7:0] INIT = 8'hA5;
  localparam logic [7:0] FADR = 8'h40;
  localparam logic [7:0] FMSK = 8'h01;
  localparam logic [7:0] FVAL = 8'h00;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       we = 1'b0;
  logic [7:0] wra = 8'h00;
  logic [7:0] wrd = 8'h00;
  logic [7:0] rda = 8'h00;
  logic       fault_en = 1'b0;
  logic [7:0] rdd;
  logic       ready;
  logic [8:0] wcount;

  int checks = 0;
  int errors = 0;

  mem_system #(
    .INIT_VAL  (INIT),
    .FAULT_ADDR(FADR),
    .FAULT_MASK(FMSK),
    .FAULT_VAL (FVAL)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .we      (we),
    .wra     (wra),
    .wrd     (wrd),
    .rda     (rda),
    .fault_en(fault_en),
    .rdd     (rdd),
    .ready   (ready),
    .wcount  (wcount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [8:0] act,
                     input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fault_fn(input logic [7:0] v);
    return (v & ~FMSK) | (FVAL & FMSK);
  endfunction

  // Model: a write sampled at edge k is seen by reads sampled at k+1+,
  // and is counted in wcount after edge k+1.
  logic [7:0] m_mem [0:255];

  initial begin
    int k;
    int cap;
    logic [7:0] e_rdd;
    logic       e_rdy;
    int         e_wc;
    k = 0;
    cap = 0;
    forever begin
      @(posedge clock);
      if (!reset) begin
        k = 0;
        cap = 0;
        e_rdd = 8'h00;
        e_rdy = 1'b0;
        e_wc = 0;
      end else begin
        k++;
        e_rdy = (k >= 256);
        e_wc = (cap > 511) ? 511 : cap;
        e_rdd = 8'h00;
        if (k > 256) begin
          e_rdd = m_mem[rda];
          if (fault_en && rda == FADR) e_rdd = fault_fn(e_rdd);
        end
        if (k == 256)
          for (int a = 0; a < 256; a++) m_mem[a] = INIT;
        if (k > 256 && we) begin
          m_mem[wra] = wrd;
          cap++;
        end
      end
      #1;
      chk("cyc_rdd", {1'b0, rdd}, {1'b0, e_rdd});
      chk("cyc_ready", {8'h00, ready}, {8'h00, e_rdy});
      chk("cyc_wcount", wcount, e_wc[8:0]);
    end
  end

  task automatic step(input logic w, input logic [7:0] wa,
                      input logic [7:0] wd, input logic [7:0] ra,
                      input logic fe);
    we = w;
    wra = wa;
    wrd = wd;
    rda = ra;
    fault_en = fe;
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic assert_rst(input string nm);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk({nm, "_rdd"}, {1'b0, rdd}, 9'h000);
    chk({nm, "_ready"}, {8'h00, ready}, 9'h000);
    chk({nm, "_wcount"}, wcount, 9'h000);
  endtask

  task automatic release_rst();
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic logic [7:0] pick_addr();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return 8'hFF;
    if (s == 1) return FADR;
    if (s < 5) return 8'(32'h80 + $urandom_range(0, 3));
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    release_rst();

    idle(255);
    chk("ready_255", {8'h00, ready}, 9'h000);
    idle(1);
    chk("ready_256", {8'h00, ready}, 9'h001);

    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("init_rd0", {1'b0, rdd}, 9'h0A5);
    step(1'b0, 8'h00, 8'h00, 8'h80, 1'b0);
    chk("init_rd128", {1'b0, rdd}, 9'h0A5);
    step(1'b0, 8'h00, 8'h00, 8'hFF, 1'b0);
    chk("init_rd255", {1'b0, rdd}, 9'h0A5);

    step(1'b1, 8'h10, 8'h3C, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 8'h10, 1'b0);
    chk("fwd_rdd", {1'b0, rdd}, 9'h03C);
    chk("fwd_wcount", wcount, 9'h001);

    step(1'b1, 8'h20, 8'h11, 8'h00, 1'b0);
    step(1'b1, 8'h20, 8'h22, 8'h00, 1'b0);
    step(1'b1, 8'h20, 8'h33, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 8'h20, 1'b0);
    chk("b2b_rdd", {1'b0, rdd}, 9'h033);
    chk("b2b_wcount", wcount, 9'h004);

    step(1'b1, 8'h50, 8'h77, 8'h50, 1'b0);
    chk("same_edge_rdd", {1'b0, rdd}, 9'h0A5);

    step(1'b1, 8'h40, 8'hFF, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 8'h40, 1'b1);
    chk("fault_on", {1'b0, rdd}, 9'h0FE);
    step(1'b0, 8'h00, 8'h00, 8'h40, 1'b0);
    chk("fault_off", {1'b0, rdd}, 9'h0FF);

    step(1'b1, 8'hFF, 8'h5A, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 8'hFF, 1'b0);
    chk("addr_ff", {1'b0, rdd}, 9'h05A);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("addr_00_no_alias", {1'b0, rdd}, 9'h0A5);

    for (int i = 0; i < 1000; i++)
      step($urandom_range(0, 3) != 0, pick_addr(),
           8'($urandom_range(0, 255)), pick_addr(),
           $urandom_range(0, 1) == 1);
    for (int i = 0; i < 520; i++)
      step(1'b1, pick_addr(), 8'($urandom_range(0, 255)),
           pick_addr(), $urandom_range(0, 1) == 1);
    idle(1);
    chk("wcount_sat", wcount, 9'h1FF);

    step(1'b1, 8'h60, 8'h99, 8'h00, 1'b0);
    assert_rst("rst_run");
    release_rst();
    idle(256);
    step(1'b0, 8'h00, 8'h00, 8'h60, 1'b0);
    chk("rst_run_rd", {1'b0, rdd}, 9'h0A5);
    chk("rst_run_wc", wcount, 9'h000);

    idle(2);
    assert_rst("rst_a");
    release_rst();
    idle(100);
    assert_rst("rst_mid");
    repeat (2) @(posedge clock);
    release_rst();
    idle(255);
    chk("resweep_255", {8'h00, ready}, 9'h000);
    idle(1);
    chk("resweep_256", {8'h00, ready}, 9'h001);

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1) == 1, pick_addr(),
           8'($urandom_range(0, 255)), pick_addr(),
           $urandom_range(0, 1) == 1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
